// File: rtl/fifo_defs_pkg.sv
// Shared definitions for the async FIFO.
// Provides the FIFO word width used by the write-side logic.
package fifo_defs_pkg;
    parameter int DATASIZE = 16;
endpackage

// File: rtl/fifo_wr_arbiter.sv
// Write-side arbiter for the async FIFO, in the wclk domain.
// Round-robin burst arbitration of NREQ requesters onto one write port.
//
// Ports:
//   wclk, wrst_n   write clock, async active-low reset
//   req            per-requester word valid
//   req_data       flattened words, requester i at [i*DATASIZE +: DATASIZE]
//   req_last       current word of requester i ends its burst
//   gnt            one-hot combinational accept (taken at this edge)
//   wfull          FIFO full
//   wdata, wack    registered write word / write request
//   owner, busy    current burst owner, high while bursting
//
// Optional: define FIFO_WR_ARB_PRIO_EN to give requester 0 priority
// at arbitration; requesters 1..NREQ-1 stay round-robin.
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int BURST_LEN = 8,
    parameter int DATASIZE  = fifo_defs_pkg::DATASIZE,
    localparam int OW       = $clog2(NREQ)
) (
    input  logic                     wclk,
    input  logic                     wrst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DATASIZE-1:0] req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          gnt,
    input  logic                     wfull,
    output logic [DATASIZE-1:0]      wdata,
    output logic                     wack,
    output logic [OW-1:0]            owner,
    output logic                     busy
);

    localparam int CW = 8;
    localparam logic [CW-1:0] CNT_MAX = CW'(BURST_LEN - 1);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t              state_q;
    logic [OW-1:0]       owner_q;
    logic [OW-1:0]       last_q;
    logic [OW-1:0]       last_d;
    logic [CW-1:0]       cnt_q;
    logic [DATASIZE-1:0] wdata_q;
    logic                wack_q;

    logic                take;
    logic                win_ok;
    logic [OW-1:0]       win_idx;
    logic [DATASIZE-1:0] owner_data;

    assign busy  = (state_q == BURST);
    assign owner = owner_q;
    assign wdata = wdata_q;
    assign wack  = wack_q;

    // A held word blocks new accepts until the FIFO drains it.
    assign take = busy & req[owner_q] & (~wack_q | ~wfull);
    assign gnt  = take ? (NREQ'(1) << owner_q) : '0;

    assign owner_data = req_data[int'(owner_q)*DATASIZE +: DATASIZE];

    // Scan from the requester after the last winner, wrapping;
    // out-of-range indices never appear since the modulo is NREQ.
    always_comb begin
        logic [NREQ-1:0] cand;
        int idx;
        cand    = req;
        win_ok  = 1'b0;
        win_idx = '0;
        idx     = 0;
`ifdef FIFO_WR_ARB_PRIO_EN
        cand[0] = 1'b0;
`endif
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_q) + k) % NREQ;
            if (!win_ok && cand[idx]) begin
                win_ok  = 1'b1;
                win_idx = OW'(idx);
            end
        end
`ifdef FIFO_WR_ARB_PRIO_EN
        if (req[0]) begin
            win_ok  = 1'b1;
            win_idx = '0;
        end
`endif
    end

    // Requester 0 stays out of the rotation when it has priority.
    always_comb begin
        last_d = owner_q;
`ifdef FIFO_WR_ARB_PRIO_EN
        if (owner_q == '0) begin
            last_d = last_q;
        end
`endif
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= OW'(NREQ - 1);
            cnt_q   <= '0;
            wdata_q <= '0;
            wack_q  <= 1'b0;
        end else begin
            // The output word lives independently of the FSM so a
            // stalled word completes across IDLE and the next burst.
            if (take) begin
                wdata_q <= owner_data;
                wack_q  <= 1'b1;
            end else if (!wfull || !wack_q) begin
                wack_q  <= 1'b0;
            end

            unique case (state_q)
                IDLE: begin
                    if (win_ok) begin
                        owner_q <= win_idx;
                        cnt_q   <= '0;
                        state_q <= BURST;
                    end
                end
                BURST: begin
                    if (take) begin
                        cnt_q <= cnt_q + CW'(1);
                        if (req_last[owner_q] || cnt_q == CNT_MAX) begin
                            state_q <= IDLE;
                            last_q  <= last_d;
                        end
                    end else if (!req[owner_q]) begin
                        state_q <= IDLE;
                        last_q  <= last_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Write-side controller for the async FIFO memory, in the write clock domain.
- Shares the single FIFO write port (wdata/wack, throttled by wfull) between NREQ requesters.
- Uses round-robin burst arbitration.
- Drives a registered write word that is held stable under wfull backpressure.

Parameters:
- NREQ, 4, number of requesters (2..8).
- BURST_LEN, 8, maximum words accepted per grant before re-arbitration (1..255).
- DATASIZE, from definitions package, FIFO word width.

Ports:
- wclk  input  1  write-domain clock.
- wrst_n  input  1  reset, asynchronous, active-low.
- req  input  NREQ  per-requester "word valid".
- req_data  input  NREQ*DATASIZE  flattened words; requester i occupies bits [i*DATASIZE +: DATASIZE].
- req_last  input  NREQ  marks the current word of requester i as last of its burst.
- gnt  output  NREQ  one-hot combinational accept; the word is taken at this wclk edge.
- wfull  input  1  FIFO full, from the write-pointer/full logic.
- wdata  output  DATASIZE  registered write word to FIFO memory.
- wack  output  1  registered write request to FIFO memory.
- owner  output  $clog2(NREQ)  current burst owner; valid while busy.
- busy  output  1  high in state BURST.

Behaviour:
- Reset (async, wrst_n=0):
  - state=IDLE, wack=0, wdata=0, owner=0, busy=0, gnt=0.
  - burst counter cnt=0; last_winner=NREQ-1, so requester 0 wins first.
- Output register semantics:
  - The FIFO memory writes on a wclk edge when wack & ~wfull.
  - While wack=1 & wfull=1, wdata and wack hold unchanged.
  - take = req[owner] & busy & (~wack | ~wfull).
  - gnt[owner]=take; all other gnt bits are 0.
  - On take: wdata<=req_data[owner], wack<=1, cnt<=cnt+1.
  - On no take with (~wfull | ~wack): wack<=0.
- States:
  - IDLE:
    - If |req, select the first i with req[i]=1 scanning last_winner+1, +2, ..., wrapping modulo NREQ.
    - owner<=i, cnt<=0, state<=BURST.
    - gnt=0 in IDLE, so there is always one arbitration cycle per burst.
  - BURST: ends (state<=IDLE, last_winner<=owner) on the first of:
    - take with req_last[owner]=1;
    - take with cnt==BURST_LEN-1;
    - req[owner]=0 (no take that cycle).
  - A word accepted on the ending cycle is still loaded and written normally.
- wfull during BURST:
  - gnt stalls while wack & wfull.
  - The burst does not end on stall.
  - cnt counts accepted words only.
- A pending word (wack=1) is independent of state: it completes across IDLE and the next owner's BURST.
- Requesters may change req_data only after gnt.
- Dropping req without gnt is permitted and ends the burst.
- Simultaneous requests: only the round-robin winner is served; others wait in order, so the max wait is (NREQ-1) bursts.
- Reset mid-burst or with a held word: the word is discarded, wack=0 immediately (async).
- NREQ not a power of two: the scan skips non-existent indices; owner never exceeds NREQ-1.

Optional Feature:
- Macro FIFO_WR_ARB_PRIO_EN.
- Defined:
  - In IDLE, req[0]=1 always wins, regardless of last_winner.
  - last_winner is not updated by requester 0's bursts.
  - Requesters 1..NREQ-1 are round-robin among themselves.
  - Requester 0 cannot preempt a running burst.
- Undefined: pure round-robin as above.

Test Plan:
- Reset, req=4'b0001, 3 words, req_last on the 3rd, wfull=0 -> owner=0; gnt[0] on cycles 2,3,4; wack high cycles 3-5 carrying words in order; busy falls after the 3rd gnt.
- req=4'b1111 continuously, no req_last, BURST_LEN=8 -> bursts of exactly 8 words, owners 0,1,2,3,0; one IDLE cycle between bursts; no gnt in IDLE.
- Requester 2 bursting, wfull=1 for 5 cycles with wack=1 -> wdata/wack stable, gnt=0 for 5 cycles, cnt unchanged; after wfull=0 the next gnt follows on the same edge the held word writes.
- Requester 1 drops req after 2 words -> burst ends with cnt=2, last_winner=1; the next pending requester 2 wins.
- Assert wrst_n=0 mid-burst with wack=1, wfull=1 -> wack=0, wdata=0, busy=0 immediately; after release, requester 0 wins first.
- With FIFO_WR_ARB_PRIO_EN, req=4'b1110 then req[0] raised mid-burst of requester 1 -> requester 1 finishes; requester 0 wins the next arbitration; requester 2 follows.
